// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: shares one multi-cycle memory between the
// MEM stage and an external loader port, with bounded CPU priority.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] ext_rdata,
    output logic        ext_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q;
    logic          owner_q;      // 0 = CPU, 1 = EXT
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] starve_q;
    logic          cmd_we_q;
    logic [31:0]   cmd_addr_q;
    logic [31:0]   cmd_wdata_q;
    logic          mem_en_q;
    logic          ext_ack_q;
    logic [31:0]   cpu_rdata_q;
    logic [31:0]   ext_rdata_q;

    logic gnt_cpu;
    logic gnt_ext;

    always_comb begin
        gnt_cpu = cpu_req && (!ext_req || (starve_q != SW'(STARVE_MAX)));
        gnt_ext = ext_req && !gnt_cpu;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_cpu || gnt_ext) begin
                        owner_q     <= gnt_ext;
                        cmd_we_q    <= gnt_ext ? ext_we    : cpu_we;
                        cmd_addr_q  <= gnt_ext ? ext_addr  : cpu_addr;
                        cmd_wdata_q <= gnt_ext ? ext_wdata : cpu_wdata;
                        cnt_q       <= CW'(MEM_LATENCY - 1);
                        mem_en_q    <= 1'b1;
                        state_q     <= ACCESS;
                        // Count only CPU wins that made a pending EXT request wait
                        if (gnt_ext || !ext_req)
                            starve_q <= '0;
                        else if (starve_q != SW'(STARVE_MAX))
                            starve_q <= starve_q + 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        mem_en_q  <= 1'b0;
                        ext_ack_q <= owner_q;
                        state_q   <= RESP;
                        if (!cmd_we_q) begin
                            if (owner_q) ext_rdata_q <= mem_rdata;
                            else         cpu_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    ext_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The CPU's own RESP cycle releases the stall so the completing instruction retires
    assign cpu_stall = reset && cpu_req && !((state_q == RESP) && !owner_q);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_en_q && cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign ext_ack   = ext_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory
// (read data combinational from the held address, write on the clock edge).
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned L = 2;
    localparam int unsigned S = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a = '0;
    logic [31:0] pre_d = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(S)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clock) begin
        if (pre_en)
            mem[pre_a] <= pre_d;
        else if (mem_en && mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        next_cycle();
        pre_en = 1'b0;
    endtask

    // One CPU access from IDLE; checks stall/mem_en per cycle and load data in RESP
    task automatic cpu_op(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int unsigned c = 0; c <= L + 1; c++) begin
            #1;
            check($sformatf("%s_stall_c%0d", tag, c), {31'b0, cpu_stall}, {31'b0, c <= L});
            check($sformatf("%s_en_c%0d", tag, c), {31'b0, mem_en}, {31'b0, c >= 1 && c <= L});
            if (c == 1) check($sformatf("%s_addr", tag), mem_addr, a);
            if (c == L + 1) check($sformatf("%s_rdata", tag), cpu_rdata, exp_rd);
            next_cycle();
        end
        cpu_req = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic        prev_en;
        int unsigned nev;
        int unsigned ncpu;

        cpu_req = 1'b1;
        preload(8'd4,  32'hDEADBEEF);
        preload(8'd16, 32'hA5A5A5A5);
        preload(8'd17, 32'hCAFEF00D);
        #1;
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_en",    {31'b0, mem_en},    32'd0);
        check("rst_we",    {31'b0, mem_we},    32'd0);
        check("rst_addr",  mem_addr,  32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_crd",   cpu_rdata, 32'd0);
        check("rst_erd",   ext_rdata, 32'd0);
        check("rst_ack",   {31'b0, ext_ack}, 32'd0);
        cpu_req = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();

        cpu_op("load10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        cpu_op("st20", 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF);
        check("mem20", mem[8], 32'h12345678);
        cpu_op("ld20", 1'b0, 32'h20, 32'h0, 32'h12345678);

        // Simultaneous request: CPU first, then EXT read of 0x44
        ext_we = 1'b0; ext_addr = 32'h44; cpu_we = 1'b0; cpu_addr = 32'h10;
        for (int unsigned c = 0; c <= 9; c++) begin
            if (c == 0) begin cpu_req = 1'b1; ext_req = 1'b1; end
            if (c == 4) cpu_req = 1'b0;
            if (c == 8) ext_req = 1'b0;
            #1;
            if (c == 1) check("sim_cpu_first", mem_addr, 32'h10);
            if (c == 3) check("sim_cpu_stall3", {31'b0, cpu_stall}, 32'd0);
            if (c == 5) check("sim_ext_addr", mem_addr, 32'h44);
            if (c == 5) check("sim_ext_en", {31'b0, mem_en}, 32'd1);
            check($sformatf("sim_ack_c%0d", c), {31'b0, ext_ack}, {31'b0, c == 7});
            if (c == 7) check("sim_erd", ext_rdata, 32'hCAFEF00D);
            if (c == 9) check("sim_idle_en", {31'b0, mem_en}, 32'd0);
            next_cycle();
        end
        #1;

        // Starvation bound: CPU at 0,4,8,12, EXT at 16, then the pattern repeats
        cpu_addr = 32'h10; ext_addr = 32'h40; ext_we = 1'b0;
        cpu_req = 1'b1; ext_req = 1'b1;
        prev_en = 1'b0; nev = 0; ncpu = 0;
        for (int unsigned c = 0; c < 40; c++) begin
            #1;
            if (mem_en && !prev_en) begin
                if (nev < 10)
                    check($sformatf("stv_owner_ev%0d", nev), {31'b0, mem_addr == 32'h40},
                          {31'b0, (nev % 5) == 4});
                if (mem_addr == 32'h10 && nev < 5) ncpu++;
                nev++;
            end
            prev_en = mem_en;
            check($sformatf("stv_ack_c%0d", c), {31'b0, ext_ack}, {31'b0, c == 19 || c == 39});
            check($sformatf("stv_stall_c%0d", c), {31'b0, cpu_stall},
                  {31'b0, !((c % 4) == 3 && (c % 20) != 19)});
            next_cycle();
        end
        check("stv_cpu_grants", ncpu, 32'd4);
        check("stv_events", nev, 32'd10);
        check("stv_erd", ext_rdata, 32'hA5A5A5A5);
        cpu_req = 1'b0; ext_req = 1'b0;
        next_cycle();

        // EXT read withdrawn in first ACCESS cycle still completes once
        ext_addr = 32'h44; ext_we = 1'b0; ext_req = 1'b1;
        nev = 0;
        for (int unsigned c = 0; c <= 6; c++) begin
            if (c == 1) ext_req = 1'b0;
            #1;
            if (ext_ack) nev++;
            check($sformatf("wd_ack_c%0d", c), {31'b0, ext_ack}, {31'b0, c == 3});
            if (c >= 4) check($sformatf("wd_en_c%0d", c), {31'b0, mem_en}, 32'd0);
            next_cycle();
        end
        check("wd_ack_count", nev, 32'd1);
        check("wd_erd", ext_rdata, 32'hCAFEF00D);

        // Reset asserted mid-access on a CPU store
        cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55; cpu_req = 1'b1;
        next_cycle();
        #1;
        check("mid_en_pre", {31'b0, mem_en}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_en",    {31'b0, mem_en},    32'd0);
        check("mid_we",    {31'b0, mem_we},    32'd0);
        check("mid_stall", {31'b0, cpu_stall}, 32'd0);
        check("mid_ack",   {31'b0, ext_ack},   32'd0);
        check("mid_crd",   cpu_rdata, 32'd0);
        check("mid_addr",  mem_addr,  32'd0);
        cpu_req = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        next_cycle();
        exp_rd = 32'hDEADBEEF;
        cpu_op("post_rst", 1'b0, 32'h10, 32'h0, exp_rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
